pll_reset_sequencer: RTL and testbench

//  Sequences the 4-output clock PLL (24 MHz ref -> 48/24/3/2.5 MHz) from power-up and after lock loss.

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/lock_sync.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } seq_state_e;

  // Bits needed to hold 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag onto refclk.
module lock_sync (
  input  logic refclk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock, then releases the per-domain resets in
// a staggered order; re-sequences on lock loss, lock timeout or restart.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 24,
  parameter int LOCK_STABLE  = 2400,
  parameter int LOCK_TIMEOUT = 24000,
  parameter int LOSS_FILT    = 4,
  parameter int N_DOM        = 4,
  parameter int STAGGER      = 16,
  parameter int RETRY_W      = 4
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               restart,
  input  logic               clr_status,
  output logic               pll_rst,
  output logic [N_DOM-1:0]   dom_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         seq_state
);

  localparam int REL_LAST_I = (N_DOM - 1) * STAGGER;
  localparam int SEQ_W      = cnt_width(max_int(RST_CYCLES, REL_LAST_I));
  localparam int STB_W      = cnt_width(LOCK_STABLE);
  localparam int TMO_W      = cnt_width(LOCK_TIMEOUT);
  localparam int LOSS_W     = cnt_width(LOSS_FILT);

  localparam logic [SEQ_W-1:0]  RST_LAST  = SEQ_W'(RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0]  REL_LAST  = SEQ_W'(REL_LAST_I);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILT - 1);

  logic lk_s;

  lock_sync u_lock_sync (
    .refclk   (refclk),
    .rst      (rst),
    .async_in (pll_locked),
    .sync_out (lk_s)
  );

  seq_state_e         state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d, seq_inc;
  logic [STB_W-1:0]   stable_q, stable_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               pll_rst_q, pll_rst_d;
  logic [N_DOM-1:0]   dom_rst_q, dom_rst_d;
  logic               ready_q, ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               enter_rst;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    seq_inc     = seq_q + 1'b1;
    stable_d    = stable_q;
    tmo_d       = tmo_q;
    loss_d      = loss_q;
    pll_rst_d   = pll_rst_q;
    dom_rst_d   = dom_rst_q;
    ready_d     = ready_q;
    lock_lost_d = lock_lost_q & ~clr_status;
    retry_d     = clr_status ? '0 : retry_q;
    enter_rst   = 1'b0;

    case (state_q)
      PLL_RST: begin
        if (seq_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          stable_d  = '0;
          tmo_d     = '0;
        end else begin
          seq_d = seq_inc;
        end
      end

      WAIT_LOCK: begin
        stable_d = lk_s ? stable_q + 1'b1 : '0;
        tmo_d    = tmo_q + 1'b1;
        // Lock qualification takes priority over a coincident timeout.
        if (lk_s && stable_q == STB_LAST) begin
          seq_d        = '0;
          dom_rst_d[0] = 1'b0;
          if (N_DOM == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
            loss_d  = '0;
          end else begin
            state_d = RELEASE;
          end
        end else if (tmo_q == TMO_LAST) begin
          enter_rst = 1'b1;
          retry_d   = (&retry_q) ? retry_q : retry_q + 1'b1;
        end
      end

      RELEASE: begin
        if (!lk_s) begin
          enter_rst = 1'b1;
        end else begin
          seq_d = seq_inc;
          for (int i = 1; i < N_DOM; i++) begin
            if (seq_inc == SEQ_W'(i * STAGGER)) dom_rst_d[i] = 1'b0;
          end
          if (seq_inc == REL_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
            loss_d  = '0;
          end
        end
      end

      RUN: begin
        if (!lk_s) begin
          if (loss_q == LOSS_LAST) begin
            enter_rst   = 1'b1;
            lock_lost_d = 1'b1;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end else begin
          loss_d = '0;
        end
      end

      default: enter_rst = 1'b1;
    endcase

    // A manual restart re-sequences without recording any status event.
    if (restart) begin
      enter_rst   = 1'b1;
      lock_lost_d = lock_lost_q & ~clr_status;
      retry_d     = clr_status ? '0 : retry_q;
    end

    if (enter_rst) begin
      state_d   = PLL_RST;
      seq_d     = '0;
      pll_rst_d = 1'b1;
      dom_rst_d = '1;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RST;
      seq_q       <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      dom_rst_q   <= '1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      dom_rst_q   <= dom_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst   = dom_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer (LOCK_STABLE=20, LOCK_TIMEOUT=100).
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       clr_status = 1'b0;
  logic       pll_rst;
  logic [3:0] dom_rst;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] seq_state;

  pll_reset_sequencer #(
    .RST_CYCLES   (24),
    .LOCK_STABLE  (20),
    .LOCK_TIMEOUT (100),
    .LOSS_FILT    (4),
    .N_DOM        (4),
    .STAGGER      (16),
    .RETRY_W      (4)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .clr_status (clr_status),
    .pll_rst    (pll_rst),
    .dom_rst    (dom_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .seq_state  (seq_state)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $error("FAIL sb_empty: observed %0d required <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_miss++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_pll(input logic v, output int n);
    n = 0;
    while (pll_rst !== v && n < 400) begin
      tick();
      n++;
    end
    if (pll_rst !== v) n = -1;
  endtask

  task automatic wait_dom(input logic [3:0] from, output int n);
    n = 0;
    while (dom_rst === from && n < 400) begin
      tick();
      n++;
    end
    if (dom_rst === from) n = -1;
  endtask

  task automatic check_reset_values(input string pfx, input logic [3:0] exp_retry,
                                    input logic exp_lost);
    push({pfx, "_pll_rst"}, 32'd1);    check(32'(pll_rst));
    push({pfx, "_dom_rst"}, 32'hF);    check(32'(dom_rst));
    push({pfx, "_ready"}, 32'd0);      check(32'(ready));
    push({pfx, "_lock_lost"}, 32'(exp_lost)); check(32'(lock_lost));
    push({pfx, "_retry"}, 32'(exp_retry));    check(32'(retry_cnt));
    push({pfx, "_state"}, 32'd0);      check(32'(seq_state));
  endtask

  // Walks dom_rst from 0xE down to 0x0 in 16-cycle steps, then checks ready.
  task automatic check_stagger(input string pfx);
    int n;
    logic [3:0] cur;
    cur = 4'hE;
    for (int s = 1; s < 4; s++) begin
      push({pfx, "_step_gap"}, 32'd16);
      wait_dom(cur, n);
      check(32'(n));
      cur = cur << 1;
      push({pfx, "_step_val"}, 32'(cur));
      check(32'(dom_rst));
    end
    push({pfx, "_ready"}, 32'd1);  check(32'(ready));
    push({pfx, "_state"}, 32'd3);  check(32'(seq_state));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, n0, n1;

    // Power-up sequence.
    ticks(5);
    check_reset_values("rst", 4'd0, 1'b0);
    rst = 1'b0;
    push("pu_pll_rst_width", 32'd24);
    n = 0;
    while (pll_rst === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    check(32'(n));
    push("pu_wait_state", 32'd1);  check(32'(seq_state));
    ticks(30);
    pll_locked = 1'b1;
    push("pu_lock_latency", 32'd22);
    wait_dom(4'hF, n);
    check(32'(n));
    push("pu_first_release", 32'hE);  check(32'(dom_rst));
    push("pu_release_state", 32'd2);  check(32'(seq_state));
    push("pu_release_pll_rst", 32'd0); check(32'(pll_rst));
    check_stagger("pu");

    // Lock glitch of 3 cycles in RUN is filtered.
    pll_locked = 1'b0;
    ticks(3);
    pll_locked = 1'b1;
    ticks(10);
    push("glitch3_ready", 32'd1);     check(32'(ready));
    push("glitch3_lock_lost", 32'd0); check(32'(lock_lost));
    push("glitch3_state", 32'd3);     check(32'(seq_state));

    // Lock low for 4 cycles is a real loss.
    pll_locked = 1'b0;
    push("loss_latency", 32'd6);
    n = 0;
    while (ready === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(32'(n));
    push("loss_dom_rst", 32'hF);   check(32'(dom_rst));
    push("loss_pll_rst", 32'd1);   check(32'(pll_rst));
    push("loss_lock_lost", 32'd1); check(32'(lock_lost));
    push("loss_state", 32'd0);     check(32'(seq_state));

    // No lock: periodic retries with saturating retry count.
    for (int k = 1; k <= 16; k++) begin
      push("retry_period", 32'd124);
      wait_pll(1'b0, n0);
      wait_pll(1'b1, n1);
      check(32'((n0 < 0 || n1 < 0) ? -1 : n0 + n1));
      push("retry_cnt", 32'((k < 15) ? k : 15));
      check(32'(retry_cnt));
    end
    push("retry_lock_lost_kept", 32'd1); check(32'(lock_lost));

    // clr_status alone clears both status fields.
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    push("clr_retry", 32'd0);     check(32'(retry_cnt));
    push("clr_lock_lost", 32'd0); check(32'(lock_lost));
    wait_pll(1'b0, n0);
    wait_pll(1'b1, n1);
    push("retry_after_clr", 32'd1); check(32'(retry_cnt));

    // clr_status on the timeout edge: the increment wins.
    ticks(123);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    push("clr_vs_timeout_retry", 32'd2); check(32'(retry_cnt));
    push("clr_vs_timeout_pll_rst", 32'd1); check(32'(pll_rst));

    // Chatter in WAIT_LOCK at stable=19 restarts qualification.
    push("chatter_pll_rst_width", 32'd24);
    wait_pll(1'b0, n);
    check(32'(n));
    pll_locked = 1'b1;
    ticks(19);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    push("chatter_release_latency", 32'd22);
    wait_dom(4'hF, n);
    check(32'(n));
    push("chatter_release_val", 32'hE); check(32'(dom_rst));

    // Lock loss during RELEASE step 2 aborts immediately.
    push("rel_step2_gap", 32'd16);
    wait_dom(4'hE, n);
    check(32'(n));
    push("rel_step2_val", 32'hC); check(32'(dom_rst));
    pll_locked = 1'b0;
    push("rel_abort_latency", 32'd3);
    n = 0;
    while (dom_rst !== 4'hF && n < 50) begin
      tick();
      n++;
    end
    check(32'(n));
    check_reset_values("rel_abort", 4'd2, 1'b0);
    pll_locked = 1'b1;
    push("rel_restart_pll_rst", 32'd24);
    wait_pll(1'b0, n);
    check(32'(n));
    push("rel_restart_latency", 32'd20);
    wait_dom(4'hF, n);
    check(32'(n));
    push("rel_restart_val", 32'hE); check(32'(dom_rst));
    check_stagger("rel_restart");

    // restart pulse in RUN.
    ticks(5);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_reset_values("restart", 4'd2, 1'b0);

    // Asynchronous rst in the middle of RELEASE.
    wait_pll(1'b0, n);
    wait_dom(4'hF, n);
    push("mid_rel_val", 32'hE); check(32'(dom_rst));
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst", 4'd0, 1'b0);
    ticks(3);
    rst = 1'b0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
